driver_cell: RTL and testbench

- Clocked digital model of the current-steering DAC segment driver.
- Takes 8 binary (LSB) and 17 thermometer (MSB) differential control lines from the segment decoder and forwards them, registered, to the DAC switch array.
- Gated by power-down (pdb), a power-up settle sequence, and a supply-window monitor on the three analog rails.
- When disabled, both legs of every output pair drive 0.

---
 rtl/driver_cell_if.sv | 35 +++
 rtl/driver_cell.sv | 121 ++++++++++++
 tb/tb_driver_cell.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/driver_cell_if.sv
// Segment-driver bus: differential control inputs, analog rail readings,
// and the registered switch-array outputs with their status flags.
interface driver_cell_if #(
    parameter int NBIN   = 8,
    parameter int NTHERM = 17
);
    logic [NBIN-1:0]   datain;
    logic [NBIN-1:0]   datainb;
    logic [NTHERM-1:0] datatherm;
    logic [NTHERM-1:0] datathermb;
    logic              pdb;
    real               vddana_1p8;
    real               vddana_0p8;
    real               vssana;
    logic [NBIN-1:0]   databinout;
    logic [NBIN-1:0]   databinoutb;
    logic [NTHERM-1:0] datathermout;
    logic [NTHERM-1:0] datathermoutb;
    logic              supply_fault;
    logic              comp_err;

    modport master (
        output datain, datainb, datatherm, datathermb, pdb,
        output vddana_1p8, vddana_0p8, vssana,
        input  databinout, databinoutb, datathermout, datathermoutb,
        input  supply_fault, comp_err
    );

    modport slave (
        input  datain, datainb, datatherm, datathermb, pdb,
        input  vddana_1p8, vddana_0p8, vssana,
        output databinout, databinoutb, datathermout, datathermoutb,
        output supply_fault, comp_err
    );
endinterface

// File: rtl/driver_cell.sv
// Current-steering DAC segment driver: registers differential control pairs
// to the switch array, gated by power-down, a wake sequence and rail monitor.
module driver_cell #(
    parameter int  NBIN         = 8,
    parameter int  NTHERM       = 17,
    parameter int  PWRUP_CYCLES = 4,
    parameter real V1P8_MIN     = 1.71,
    parameter real V1P8_MAX     = 1.89,
    parameter real V0P8_MIN     = 0.76,
    parameter real V0P8_MAX     = 0.84,
    parameter real VSS_TOL      = 0.05
) (
    input  logic         clk,
    input  logic         rst,
    driver_cell_if.slave bus
);
    localparam int CNT_W = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NBIN-1:0]   bin_q,   bin_d;
    logic [NBIN-1:0]   binb_q,  binb_d;
    logic [NTHERM-1:0] therm_q, therm_d;
    logic [NTHERM-1:0] thermb_q, thermb_d;
    logic              fault_q;
    logic              cerr_q;

    logic              supply_ok;
    logic              en;
    logic [NBIN-1:0]   bad_bin;
    logic [NTHERM-1:0] bad_therm;

    // NaN and infinities fail every window compare, so they read as out of range.
    always_comb begin
        supply_ok = (bus.vddana_1p8 >= V1P8_MIN) && (bus.vddana_1p8 <= V1P8_MAX) &&
                    (bus.vddana_0p8 >= V0P8_MIN) && (bus.vddana_0p8 <= V0P8_MAX) &&
                    (bus.vssana >= -VSS_TOL) && (bus.vssana <= VSS_TOL);
        en = (bus.pdb === 1'b1) && supply_ok;
    end

    always_comb begin
        bad_bin   = '0;
        bad_therm = '0;
        for (int i = 0; i < NBIN; i++) begin
            bad_bin[i] = ((bus.datain[i] ^ bus.datainb[i]) !== 1'b1);
        end
        for (int i = 0; i < NTHERM; i++) begin
            bad_therm[i] = ((bus.datatherm[i] ^ bus.datathermb[i]) !== 1'b1);
        end
    end

    // Data only passes while staying in ON; a non-complementary pair drives 0/0.
    always_comb begin
        bin_d    = '0;
        binb_d   = '0;
        therm_d  = '0;
        thermb_d = '0;
        if (state_q == ST_ON && en) begin
            bin_d    = bus.datain     & ~bad_bin;
            binb_d   = bus.datainb    & ~bad_bin;
            therm_d  = bus.datatherm  & ~bad_therm;
            thermb_d = bus.datathermb & ~bad_therm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            bin_q    <= '0;
            binb_q   <= '0;
            therm_q  <= '0;
            thermb_q <= '0;
            fault_q  <= 1'b0;
            cerr_q   <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            binb_q   <= binb_d;
            therm_q  <= therm_d;
            thermb_q <= thermb_d;
            fault_q  <= !supply_ok;
            cerr_q   <= (|bad_bin) || (|bad_therm);
            case (state_q)
                ST_OFF: begin
                    if (en) begin
                        state_q <= ST_WAKE;
                        cnt_q   <= '0;
                    end
                end
                ST_WAKE: begin
                    if (!en) begin
                        state_q <= ST_OFF;
                    end else if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) begin
                        state_q <= ST_ON;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_ON: begin
                    if (!en) begin
                        state_q <= ST_OFF;
                    end
                end
                default: state_q <= ST_OFF;
            endcase
        end
    end

    assign bus.databinout    = bin_q;
    assign bus.databinoutb   = binb_q;
    assign bus.datathermout  = therm_q;
    assign bus.datathermoutb = thermb_q;
    assign bus.supply_fault  = fault_q;
    assign bus.comp_err      = cerr_q;
endmodule

// File: tb/tb_driver_cell.sv
// Directed-vector bench for driver_cell: table of per-cycle stimulus with
// hand-computed outputs, plus wake/fault/reset sequences.
module tb_driver_cell;
    localparam int P = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    driver_cell_if #(.NBIN(8), .NTHERM(17)) bus ();

    driver_cell #(.NBIN(8), .NTHERM(17), .PWRUP_CYCLES(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0]  A   = 8'b11001100;
    localparam logic [7:0]  AB  = 8'b00110011;
    localparam logic [16:0] T   = 17'b11110000111100001;
    localparam logic [16:0] TB_ = 17'b00001111000011110;
    localparam logic [7:0]  B   = 8'b10101010;
    localparam logic [7:0]  BB  = 8'b01010101;
    localparam logic [16:0] U   = 17'b10101010101010101;
    localparam logic [16:0] UB  = 17'b01010101010101010;

    typedef struct {
        logic        pdb;
        logic [7:0]  din;
        logic [7:0]  dinb;
        logic [16:0] dt;
        logic [16:0] dtb;
        int          v18;
        int          v08;
        int          vss;
        logic [7:0]  eb;
        logic [7:0]  ebb;
        logic [16:0] et;
        logic [16:0] etb;
        logic        esf;
        logic        ece;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rails(input int v18, input int v08, input int vss);
        bus.vddana_1p8 = real'(v18) / 1000.0;
        bus.vddana_0p8 = real'(v08) / 1000.0;
        bus.vssana     = real'(vss) / 1000.0;
    endtask

    task automatic set_data(input logic p, input logic [7:0] d, input logic [7:0] db,
                            input logic [16:0] t, input logic [16:0] tb);
        bus.pdb        = p;
        bus.datain     = d;
        bus.datainb    = db;
        bus.datatherm  = t;
        bus.datathermb = tb;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] eb, input logic [7:0] ebb,
                              input logic [16:0] et, input logic [16:0] etb,
                              input logic esf, input logic ece);
        chk({tag, ".binout"},    32'(bus.databinout),    32'(eb));
        chk({tag, ".binoutb"},   32'(bus.databinoutb),   32'(ebb));
        chk({tag, ".thermout"},  32'(bus.datathermout),  32'(et));
        chk({tag, ".thermoutb"}, 32'(bus.datathermoutb), 32'(etb));
        chk({tag, ".supply_fault"}, 32'(bus.supply_fault), 32'(esf));
        chk({tag, ".comp_err"},  32'(bus.comp_err),      32'(ece));
    endtask

    // From OFF with good rails: P+1 zero edges, then data A/T on the outputs.
    task automatic bring_up(input string tag);
        set_rails(1800, 800, 0);
        set_data(1'b1, A, AB, T, TB_);
        for (int i = 0; i <= P; i++) begin
            step();
            check_outs($sformatf("%s.wake%0d", tag, i), 8'h00, 8'h00, 17'h0, 17'h0, 1'b0, 1'b0);
        end
        step();
        check_outs({tag, ".on"}, A, AB, T, TB_, 1'b0, 1'b0);
    endtask

    task automatic rail_fault(input string tag, input int v18, input int v08, input int vss);
        bring_up(tag);
        set_rails(v18, v08, vss);
        step();
        check_outs({tag, ".fault"}, 8'h00, 8'h00, 17'h0, 17'h0, 1'b1, 1'b0);
        set_rails(1800, 800, 0);
        set_data(1'b0, A, AB, T, TB_);
        step();
        check_outs({tag, ".off"}, 8'h00, 8'h00, 17'h0, 17'h0, 1'b0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        tbl[0]  = '{1'b0, B, BB, U, UB, 1800, 800, 0,   8'h00, 8'h00, 17'h0, 17'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, B, BB, U, UB, 1800, 800, 0,   8'h00, 8'h00, 17'h0, 17'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, B, B,  U, UB, 1800, 800, 0,   8'h00, 8'h00, 17'h0, 17'h0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, A, AB, T, TB_, 1800, 800, 0,  8'h00, 8'h00, 17'h0, 17'h0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, A, AB, T, TB_, 1800, 800, 0,  8'h00, 8'h00, 17'h0, 17'h0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, A, AB, T, TB_, 1800, 800, 0,  8'h00, 8'h00, 17'h0, 17'h0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, A, AB, T, TB_, 1800, 800, 0,  8'h00, 8'h00, 17'h0, 17'h0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, A, AB, T, TB_, 1800, 800, 0,  8'h00, 8'h00, 17'h0, 17'h0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, A, AB, T, TB_, 1800, 800, 0,  A, AB, T, TB_, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, B, BB, T, TB_, 1800, 800, 0,  B, BB, T, TB_, 1'b0, 1'b0};
        tbl[10] = '{1'b1, B, BB, U, UB, 1800, 800, 0,   B, BB, U, UB, 1'b0, 1'b0};
        tbl[11] = '{1'b1, B, 8'b01011101, U, UB, 1800, 800, 0,
                    8'b10100010, 8'b01010101, U, UB, 1'b0, 1'b1};
        tbl[12] = '{1'b1, B, BB, U, UB, 1710, 840, -50, B, BB, U, UB, 1'b0, 1'b0};
        tbl[13] = '{1'b1, B, BB, U, UB, 1890, 760, 50,  B, BB, U, UB, 1'b0, 1'b0};
        tbl[14] = '{1'b1, B, BB, U, 17'b01010101010101011, 1800, 800, 0,
                    B, BB, 17'b10101010101010100, UB, 1'b0, 1'b1};
        tbl[15] = '{1'b0, B, BB, U, UB, 1800, 800, 0,   8'h00, 8'h00, 17'h0, 17'h0, 1'b0, 1'b0};

        // Reset with bad rails and a broken pair: flags must still read 0.
        rst = 1'b1;
        set_rails(0, 0, 500);
        set_data(1'b1, A, A, T, TB_);
        step();
        step();
        check_outs("reset", 8'h00, 8'h00, 17'h0, 17'h0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            set_data(tbl[i].pdb, tbl[i].din, tbl[i].dinb, tbl[i].dt, tbl[i].dtb);
            set_rails(tbl[i].v18, tbl[i].v08, tbl[i].vss);
            step();
            check_outs($sformatf("vec%0d", i), tbl[i].eb, tbl[i].ebb, tbl[i].et, tbl[i].etb,
                       tbl[i].esf, tbl[i].ece);
        end

        rail_fault("v1p8_hi", 1900, 800, 0);
        rail_fault("v0p8_lo", 1800, 700, 0);
        rail_fault("vss_neg", 1800, 800, -100);

        // Reset mid-ON, then the full wake sequence must repeat.
        bring_up("pre_rst");
        rst = 1'b1;
        set_rails(1900, 800, 0);
        set_data(1'b1, A, A, T, TB_);
        step();
        check_outs("mid_rst", 8'h00, 8'h00, 17'h0, 17'h0, 1'b0, 1'b0);
        rst = 1'b0;
        bring_up("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
